// File: rtl/mem_arb.sv
// Two-port arbiter and wait-state sequencer for the shared async ROM/RAM bus.
// The CPU and debug ports are served round-robin on ties, and writes into the ROM window are blocked.
module mem_arb #(
    parameter int unsigned  WAIT     = 2,
    parameter logic [15:0]  ROM_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_ack,
    output logic [7:0]  dbg_rdata,
    output logic        mem_sel,
    output logic [15:0] mem_a,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        wp_hit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        we_lat;
    logic        wp_lat;

    logic        grant_any;
    logic        grant_cpu;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

    function automatic logic in_rom(input logic [15:0] a);
        return a >= ROM_BASE;
    endfunction

    // Arbitration and next-state; the port not served last time wins a tie.
    always_comb begin
        state_nx  = state;
        grant_any = 1'b0;
        grant_cpu = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = 16'h0000;
        sel_wdata = 8'h00;
        case (state)
            IDLE: begin
                grant_any = cpu_req | dbg_req;
                grant_cpu = cpu_req & (~dbg_req | (last_grant == GNT_DBG));
                sel_we    = grant_cpu ? cpu_we    : dbg_we;
                sel_addr  = grant_cpu ? cpu_addr  : dbg_addr;
                sel_wdata = grant_cpu ? cpu_wdata : dbg_wdata;
                if (grant_any) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= GNT_DBG;
            we_lat     <= 1'b0;
            wp_lat     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_a      <= 16'h0000;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'h00;
            cpu_rdata  <= 8'h00;
            dbg_rdata  <= 8'h00;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mem_sel    <= 1'b1;
                        mem_a      <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_we     <= sel_we & ~in_rom(sel_addr);
                        we_lat     <= sel_we;
                        wp_lat     <= sel_we & in_rom(sel_addr);
                        cnt        <= 4'(WAIT);
                        last_grant <= grant_cpu ? GNT_CPU : GNT_DBG;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        mem_sel <= 1'b0;
                        if (!we_lat) begin
                            if (last_grant == GNT_CPU) begin
                                cpu_rdata <= mem_rdata;
                            end else begin
                                dbg_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion strobes exist only in DONE, so a reset edge cancels them.
    assign cpu_ack = (state == DONE) && (last_grant == GNT_CPU);
    assign dbg_ack = (state == DONE) && (last_grant == GNT_DBG);
    assign wp_hit  = (state == DONE) && wp_lat;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: WAIT=2 instance checked through an ack monitor,
// plus a WAIT=0 instance exercising back-to-back CPU reads.
module tb_mem_arb;

    localparam int WAITV = 2;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata, dbg_rdata;
    logic        mem_sel, mem_we, wp_hit;
    logic [15:0] mem_a;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        z_cpu_req, z_cpu_we, z_cpu_ack;
    logic [15:0] z_cpu_addr;
    logic [7:0]  z_cpu_wdata, z_cpu_rdata;
    logic        z_dbg_ack;
    logic [7:0]  z_dbg_rdata;
    logic        z_mem_sel, z_mem_we, z_wp_hit;
    logic [15:0] z_mem_a;
    logic [7:0]  z_mem_wdata, z_mem_rdata;

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        case (a)
            16'hFF00: return 8'h4F;
            16'hFF01: return 8'h4C;
            16'h1234: return 8'h6E;
            16'h2000: return 8'h5A;
            default:  return 8'h00;
        endcase
    endfunction

    assign mem_rdata   = mem_model(mem_a);
    assign z_mem_rdata = mem_model(z_mem_a);

    mem_arb #(.WAIT(WAITV), .ROM_BASE(16'hFF00)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_sel(mem_sel), .mem_a(mem_a), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wp_hit(wp_hit)
    );

    mem_arb #(.WAIT(0), .ROM_BASE(16'hFF00)) u_dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
        .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(8'h00),
        .dbg_ack(z_dbg_ack), .dbg_rdata(z_dbg_rdata),
        .mem_sel(z_mem_sel), .mem_a(z_mem_a), .mem_we(z_mem_we), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .wp_hit(z_wp_hit)
    );

    typedef struct {
        bit         dbg;
        bit         rd;
        logic [7:0] rdata;
        bit         wp;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (cpu_ack || dbg_ack)) begin
                check("both_ack", 32'(cpu_ack & dbg_ack), 32'd0);
                check("ack_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("ack_port", 32'(dbg_ack), 32'(e.dbg));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("wp_hit", 32'(wp_hit), 32'(e.wp));
                    if (e.rd) check("rdata", 32'(e.dbg ? dbg_rdata : cpu_rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic push_exp(input bit dbg, input bit rd, input logic [7:0] rdata, input bit wp, input int c);
        exp_t e;
        e.dbg = dbg; e.rd = rd; e.rdata = rdata; e.wp = wp; e.cyc = c;
        sbq.push_back(e);
    endtask

    // Entered just after a rising edge; both ports read continuously for n grants.
    task automatic tie(input int n);
        int t0, got, k;
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h2000;
        for (int i = 0; i < n; i++)
            push_exp(i[0], 1'b1, i[0] ? 8'h5A : 8'h6E, 1'b0, t0 + 4 + 5 * i);
        got = 0; k = 0;
        while (got < n && k < 5 * n + 10) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) got++;
            k++;
        end
        check("tie_acks", 32'(got), 32'(n));
        @(posedge clk); #1;
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    // Entered just after a rising edge; single access on one port of the WAIT=2 instance.
    task automatic access(input bit dbg, input bit we, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] er, input bit ewe, input bit ewp, input bit pulse);
        int t0;
        t0 = cyc;
        if (dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        push_exp(dbg, !we, er, ewp, t0 + WAITV + 2);
        @(negedge clk);
        check("mem_sel_c0", 32'(mem_sel), 32'd0);
        for (int k = 1; k <= WAITV + 1; k++) begin
            @(posedge clk); #1;
            if (pulse && k == 1) begin dbg_req = 1'b0; cpu_req = 1'b0; end
            @(negedge clk);
            check("mem_sel_acc", 32'(mem_sel), 32'd1);
            check("mem_a", 32'(mem_a), 32'(a));
            check("mem_we", 32'(mem_we), 32'(ewe));
            if (we) check("mem_wdata", 32'(mem_wdata), 32'(d));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("mem_sel_done", 32'(mem_sel), 32'd0);
        @(posedge clk); #1;
        dbg_req = 1'b0; cpu_req = 1'b0;
        if (pulse) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("no_reaccess", 32'(mem_sel), 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

    initial begin
        logic [6:0] z_ack_exp;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 8'h00;
        z_cpu_req = 1'b0; z_cpu_we = 1'b0; z_cpu_addr = 16'h0000; z_cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_mem_sel", 32'(mem_sel), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
        check("rst_wp_hit", 32'(wp_hit), 32'd0);
        @(posedge clk); #1;

        // Simultaneous continuous requests out of reset: CPU, DBG, CPU, DBG.
        tie(4);
        repeat (2) @(posedge clk);
        #1;

        access(1'b0, 1'b0, 16'hFF00, 8'h00, 8'h4F, 1'b0, 1'b0, 1'b0);
        access(1'b1, 1'b1, 16'hFFFE, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0);
        access(1'b1, 1'b1, 16'hFEFF, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
        access(1'b1, 1'b0, 16'h2000, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1);

        // Reset during the second ACCESS cycle of a CPU read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_mem_sel", 32'(mem_sel), 32'd0);
        check("rstmid_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rstmid_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rstmid_dbg_rdata", 32'(dbg_rdata), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        tie(2);

        // WAIT=0 instance: back-to-back CPU reads with req held high.
        z_ack_exp = 7'b0100100;
        z_cpu_req = 1'b1; z_cpu_we = 1'b0; z_cpu_addr = 16'hFF00;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) z_cpu_addr = 16'hFF01;
            if (k == 6) z_cpu_req = 1'b0;
            @(negedge clk);
            check("z_cpu_ack", 32'(z_cpu_ack), 32'(z_ack_exp[k]));
            check("z_mem_sel", 32'(z_mem_sel), 32'((k == 1) || (k == 4)));
            if (k == 2) check("z_rdata_1", 32'(z_cpu_rdata), 32'h4F);
            if (k == 5) check("z_rdata_2", 32'(z_cpu_rdata), 32'h4C);
            @(posedge clk); #1;
        end
        check("z_dbg_ack", 32'(z_dbg_ack), 32'd0);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
